// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: registered MIPS conditional-branch resolver with delay-slot sequencing.
// Optional statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_resolve_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br_valid,
  input  logic [5:0]        opcode,
  input  logic [4:0]        b_code,
  input  logic [DATA_W-1:0] read_data_a,
  input  logic [DATA_W-1:0] read_data_b,
  input  logic [ADDR_W-1:0] pc,
  input  logic [15:0]       imm,
  input  logic              advance,
  output logic              redirect,
  output logic [ADDR_W-1:0] pc_target,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_data,
  output logic              slot_err,
  output logic [31:0]       br_count,
  output logic [31:0]       taken_count
);

  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [4:0] RT_BLTZ   = 5'd0;
  localparam logic [4:0] RT_BGEZ   = 5'd1;
  localparam logic [4:0] RT_BLTZAL = 5'd16;
  localparam logic [4:0] RT_BGEZAL = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SLOT  = 2'd1,
    ST_REDIR = 2'd2
  } state_e;

  state_e            state_q;
  logic              redirect_q;
  logic              link_we_q;
  logic              slot_err_q;
  logic [ADDR_W-1:0] pc_target_q;
  logic [ADDR_W-1:0] link_data_q;

  logic              accept_s;
  logic              taken_s;
  logic              links_s;
  logic              a_neg_s;
  logic              a_zero_s;
  logic [ADDR_W-1:0] target_s;
  logic [ADDR_W-1:0] link_s;

  // Signed tests reduce to the sign bit plus a zero detect.
  assign a_neg_s  = read_data_a[DATA_W-1];
  assign a_zero_s = (read_data_a == {DATA_W{1'b0}});
  assign accept_s = (state_q == ST_IDLE) && br_valid && advance;
  assign target_s = pc + ADDR_W'(32'd4) + {{(ADDR_W-18){imm[15]}}, imm, 2'b00};
  assign link_s   = pc + ADDR_W'(32'd8);

  // Branch condition and link decode.
  always_comb begin
    taken_s = 1'b0;
    links_s = 1'b0;
    case (opcode)
      OP_BEQ:  taken_s = (read_data_a == read_data_b);
      OP_BNE:  taken_s = (read_data_a != read_data_b);
      OP_BLEZ: taken_s = a_neg_s || a_zero_s;
      OP_BGTZ: taken_s = !a_neg_s && !a_zero_s;
      OP_REGIMM: begin
        case (b_code)
          RT_BLTZ:   taken_s = a_neg_s;
          RT_BGEZ:   taken_s = !a_neg_s;
          RT_BLTZAL: begin
            taken_s = a_neg_s;
            links_s = 1'b1;
          end
          RT_BGEZAL: begin
            taken_s = !a_neg_s;
            links_s = 1'b1;
          end
          default: begin
            taken_s = 1'b0;
            links_s = 1'b0;
          end
        endcase
      end
      default: begin
        taken_s = 1'b0;
        links_s = 1'b0;
      end
    endcase
  end

  // Delay-slot sequencer with registered redirect/link pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      redirect_q  <= 1'b0;
      link_we_q   <= 1'b0;
      slot_err_q  <= 1'b0;
      pc_target_q <= {ADDR_W{1'b0}};
      link_data_q <= {ADDR_W{1'b0}};
    end else begin
      redirect_q <= 1'b0;
      link_we_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            pc_target_q <= target_s;
            if (links_s) begin
              link_we_q   <= 1'b1;
              link_data_q <= link_s;
            end
            state_q <= taken_s ? ST_SLOT : ST_IDLE;
          end
        end
        ST_SLOT: begin
          if (br_valid) begin
            slot_err_q <= 1'b1;
          end
          if (advance) begin
            state_q    <= ST_REDIR;
            redirect_q <= 1'b1;
          end
        end
        ST_REDIR: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign redirect  = redirect_q;
  assign link_we   = link_we_q;
  assign link_data = link_data_q;
  assign pc_target = pc_target_q;
  assign slot_err  = slot_err_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] br_count_q;
  logic [31:0] br_count_d;
  logic [31:0] taken_count_q;
  logic [31:0] taken_count_d;

  // Saturating statistics next-state.
  always_comb begin
    br_count_d    = br_count_q;
    taken_count_d = taken_count_q;
    if (accept_s && (br_count_q != 32'hFFFF_FFFF)) begin
      br_count_d = br_count_q + 32'd1;
    end else begin
      br_count_d = br_count_q;
    end
    if (accept_s && taken_s && (taken_count_q != 32'hFFFF_FFFF)) begin
      taken_count_d = taken_count_q + 32'd1;
    end else begin
      taken_count_d = taken_count_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      br_count_q    <= 32'd0;
      taken_count_q <= 32'd0;
    end else begin
      br_count_q    <= br_count_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign br_count    = br_count_q;
  assign taken_count = taken_count_q;
`else
  assign br_count    = 32'd0;
  assign taken_count = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed branches push expected pulses,
// a negedge monitor pops and compares whenever redirect or link_we fire.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        br_valid;
  logic [5:0]  opcode;
  logic [4:0]  b_code;
  logic [31:0] read_data_a;
  logic [31:0] read_data_b;
  logic [31:0] pc;
  logic [15:0] imm;
  logic        advance;
  logic        redirect;
  logic [31:0] pc_target;
  logic        link_we;
  logic [31:0] link_data;
  logic        slot_err;
  logic [31:0] br_count;
  logic [31:0] taken_count;

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } ev_t;

  ev_t exp_link[$];
  ev_t exp_redir[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;

  branch_resolve_unit #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .br_valid    (br_valid),
    .opcode      (opcode),
    .b_code      (b_code),
    .read_data_a (read_data_a),
    .read_data_b (read_data_b),
    .pc          (pc),
    .imm         (imm),
    .advance     (advance),
    .redirect    (redirect),
    .pc_target   (pc_target),
    .link_we     (link_we),
    .link_data   (link_data),
    .slot_err    (slot_err),
    .br_count    (br_count),
    .taken_count (taken_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the head of its queue in value and cycle.
  always @(negedge clk) begin : mon
    ev_t ev;
    if (link_we) begin
      if (exp_link.size() == 0) begin
        chk("link_we_spurious", {31'd0, link_we}, 32'd0);
      end else begin
        ev = exp_link.pop_front();
        chk("link_cycle", cyc, ev.cyc);
        chk("link_data", link_data, ev.val);
      end
    end else if (exp_link.size() > 0 && exp_link[0].cyc <= cyc) begin
      ev = exp_link.pop_front();
      chk("link_we_missing", {31'd0, link_we}, 32'd1);
    end
    if (redirect) begin
      if (exp_redir.size() == 0) begin
        chk("redirect_spurious", {31'd0, redirect}, 32'd0);
      end else begin
        ev = exp_redir.pop_front();
        chk("redirect_cycle", cyc, ev.cyc);
        chk("pc_target", pc_target, ev.val);
      end
    end else if (exp_redir.size() > 0 && exp_redir[0].cyc <= cyc) begin
      ev = exp_redir.pop_front();
      chk("redirect_missing", {31'd0, redirect}, 32'd1);
    end
  end

  task automatic idle(input int n);
    br_valid = 1'b0;
    advance  = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  // Issue one branch with hand-computed expectations; caller sits #1 after a posedge.
  task automatic issue(input logic [5:0] op, input logic [4:0] bc,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pcv, input logic [15:0] immv,
                       input bit exp_taken, input bit exp_links,
                       input logic [31:0] exp_tgt, input logic [31:0] exp_ldata,
                       input int stall, input bit slot_br);
    ev_t ev;
    if (exp_links) begin
      ev.cyc = cyc + 1;
      ev.val = exp_ldata;
      exp_link.push_back(ev);
    end
    if (exp_taken) begin
      ev.cyc = cyc + 2 + stall;
      ev.val = exp_tgt;
      exp_redir.push_back(ev);
    end
    opcode = op; b_code = bc; read_data_a = a; read_data_b = b; pc = pcv; imm = immv;
    br_valid = 1'b1;
    advance  = 1'b1;
    @(posedge clk);
    #1;
    chk("pc_target_after_accept", pc_target, exp_tgt);
    br_valid = 1'b0;
    if (exp_taken) begin
      for (int i = 0; i <= stall; i++) begin
        br_valid = slot_br;
        advance  = (i == stall);
        @(posedge clk);
        #1;
      end
      br_valid = 1'b0;
      advance  = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected under 10000", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; br_valid = 1'b0; advance = 1'b0; opcode = 6'd0; b_code = 5'd0;
    read_data_a = 32'd0; read_data_b = 32'd0; pc = 32'd0; imm = 16'd0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    chk("rst_link_we", {31'd0, link_we}, 32'd0);
    chk("rst_slot_err", {31'd0, slot_err}, 32'd0);
    chk("rst_pc_target", pc_target, 32'd0);
    chk("rst_link_data", link_data, 32'd0);
    chk("rst_br_count", br_count, 32'd0);
    chk("rst_taken_count", taken_count, 32'd0);
    reset = 1'b0;
    idle(1);

    // op     bc      a              b             pc             imm       tk lk target         link
    issue(6'h04, 5'd0,  32'd7,         32'd7,        32'h0000_0100, 16'h0003, 1, 0, 32'h0000_0110, 32'd0, 0, 0);
    issue(6'h07, 5'd0,  32'hFFFF_FE9B, 32'd0,        32'h0000_0200, 16'h0005, 0, 0, 32'h0000_0218, 32'd0, 0, 0);
    issue(6'h01, 5'd0,  32'hFFFF_FE9B, 32'd0,        32'h0000_0300, 16'hFFFE, 1, 0, 32'h0000_02FC, 32'd0, 0, 0);
    issue(6'h05, 5'd0,  32'd9,         32'd9,        32'h0000_0040, 16'h0000, 0, 0, 32'h0000_0044, 32'd0, 0, 0);
    issue(6'h02, 5'd0,  32'd0,         32'd0,        32'h0000_0080, 16'h0001, 0, 0, 32'h0000_0088, 32'd0, 0, 0);
    issue(6'h06, 5'd0,  32'd0,         32'd3,        32'h0000_0600, 16'h0002, 1, 0, 32'h0000_060C, 32'd0, 0, 0);
    issue(6'h01, 5'd1,  32'h7FFF_FFFF, 32'd0,        32'h0000_0700, 16'h0000, 1, 0, 32'h0000_0704, 32'd0, 0, 0);
    issue(6'h01, 5'd16, 32'd1,         32'd0,        32'h0000_0800, 16'h0004, 0, 1, 32'h0000_0814, 32'h0000_0808, 0, 0);
    issue(6'h07, 5'd0,  32'd1,         32'd0,        32'h0000_0900, 16'h0001, 1, 0, 32'h0000_0908, 32'd0, 0, 0);
    issue(6'h04, 5'd0,  32'd0,         32'd0,        32'hFFFF_FFFC, 16'h0000, 1, 0, 32'h0000_0000, 32'd0, 0, 0);
    issue(6'h05, 5'd0,  32'd1,         32'd0,        32'h0000_0000, 16'hFFFC, 1, 0, 32'hFFFF_FFF4, 32'd0, 0, 0);
    issue(6'h01, 5'd17, 32'd0,         32'd0,        32'h0000_2000, 16'hFFFF, 1, 1, 32'h0000_2000, 32'h0000_2008, 0, 0);
    issue(6'h05, 5'd0,  32'd1,         32'd2,        32'h0000_0400, 16'h0010, 1, 0, 32'h0000_0444, 32'd0, 4, 0);
    idle(2);

    // Branch in the delay slot: ignored, flagged, sticky.
    do_reset();
    issue(6'h01, 5'd0,  32'hFFFF_FFFF, 32'd0,        32'h0000_0500, 16'h0001, 1, 0, 32'h0000_0508, 32'd0, 0, 1);
    chk("slot_err_set", {31'd0, slot_err}, 32'd1);
    idle(3);
    chk("slot_err_sticky", {31'd0, slot_err}, 32'd1);
`ifdef BRANCH_STATS_EN
    chk("br_count", br_count, 32'd1);
    chk("taken_count", taken_count, 32'd1);
`else
    chk("br_count_tied", br_count, 32'd0);
    chk("taken_count_tied", taken_count, 32'd0);
`endif

    // Reset while in the delay slot abandons the redirect.
    begin
      ev_t ev;
      ev.cyc = cyc + 1;
      ev.val = 32'h0000_1008;
      exp_link.push_back(ev);
    end
    opcode = 6'h01; b_code = 5'd17; read_data_a = 32'd5; read_data_b = 32'd0;
    pc = 32'h0000_1000; imm = 16'h0010; br_valid = 1'b1; advance = 1'b1;
    @(posedge clk);
    #1;
    br_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("srst_redirect", {31'd0, redirect}, 32'd0);
    chk("srst_link_we", {31'd0, link_we}, 32'd0);
    chk("srst_slot_err", {31'd0, slot_err}, 32'd0);
    chk("srst_pc_target", pc_target, 32'd0);
    chk("srst_link_data", link_data, 32'd0);
    chk("srst_br_count", br_count, 32'd0);
    chk("srst_taken_count", taken_count, 32'd0);
    idle(5);

    chk("link_queue_drained", exp_link.size(), 32'd0);
    chk("redirect_queue_drained", exp_redir.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
